spi_master_wide: RTL and testbench

//  Parametrised SPI master on the simple ctrl_wr/ctrl_rd/ctrl_done register bus used by the menu/OSD CPUs.

---
 rtl/spi_master_wide_if.sv | 11 +
 rtl/spi_master_wide.sv | 138 +++++++++++++
 tb/tb_spi_master_wide.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_wide_if.sv
// spi_master_wide_if: ctrl register bus between a menu/OSD CPU (master) and the SPI block (slave).
interface spi_master_wide_if;
    logic        ctrl_wr;
    logic        ctrl_rd;
    logic [7:0]  ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    modport master (output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat, input ctrl_rdat, ctrl_done);
    modport slave  (input ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat, output ctrl_rdat, ctrl_done);
endinterface

// File: rtl/spi_master_wide.sv
// spi_master_wide: register-bus SPI master, 1..DATA_WIDTH bits, all CPOL/CPHA modes, wide prescaler.
// Define SPI_MASTER_WIDE_LSB_EN to implement the MODE.lsb LSB-first shift order.
module spi_master_wide #(
    parameter int DATA_WIDTH = 32,
    parameter int CS_LENGTH  = 8,
    parameter int PRESC_W    = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    spi_master_wide_if.slave     bus,
    output logic [CS_LENGTH-1:0] spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TAIL} state_t;
    state_t state, state_nx;
    logic [PRESC_W-1:0]    presc, act_presc, hp;
    logic [CS_LENGTH-1:0]  cs;
    logic [DATA_WIDTH-1:0] data, mask, top, shifted;
    logic [5:0]            nbits, act_nbits, nb_w;
    logic [6:0]            edge_cnt;
    logic [31:0]           rval;
    logic cpol, cpha, act_cpol, act_cpha, lsb, tx_bit;
    logic is_wr, is_rd, data_wr, reg_acc, start, half_end, last_edge, busy;
    logic presc_wr, cs_wr, mode_wr, nbits_wr;

    assign is_wr     = bus.ctrl_wr && !bus.ctrl_done;
    assign is_rd     = bus.ctrl_rd && !bus.ctrl_wr && !bus.ctrl_done;
    assign presc_wr  = is_wr && bus.ctrl_addr == 8'h00;
    assign cs_wr     = is_wr && bus.ctrl_addr == 8'h04;
    assign data_wr   = is_wr && bus.ctrl_addr == 8'h08;
    assign mode_wr   = is_wr && bus.ctrl_addr == 8'h0C;
    assign nbits_wr  = is_wr && bus.ctrl_addr == 8'h10;
    // DATA writes complete from TAIL; everything else completes one cycle after acceptance
    assign reg_acc   = (is_wr && !data_wr) || is_rd;
    assign start     = data_wr && state == IDLE;
    assign busy      = state != IDLE;
    assign half_end  = state == SHIFT && hp == act_presc;
    assign last_edge = half_end && edge_cnt == {act_nbits, 1'b0} - 7'd1;
    assign nb_w      = bus.ctrl_wdat[5:0];
    assign mask      = {DATA_WIDTH{1'b1}} >> (7'(DATA_WIDTH) - {1'b0, act_nbits});
    assign top       = mask & ~(mask >> 1);

`ifdef SPI_MASTER_WIDE_LSB_EN
    logic act_lsb;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            lsb     <= 1'b0;
            act_lsb <= 1'b0;
        end else begin
            if (mode_wr) lsb <= bus.ctrl_wdat[2];
            if (start) act_lsb <= lsb;
        end
    assign tx_bit  = act_lsb ? data[0] : |(data & top);
    assign shifted = act_lsb ? (data >> 1) | (spi_miso ? top : '0)
                             : {data[DATA_WIDTH-2:0], spi_miso} & mask;
`else
    assign lsb     = 1'b0;
    assign tx_bit  = |(data & top);
    assign shifted = {data[DATA_WIDTH-2:0], spi_miso} & mask;
`endif

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state == IDLE  ? (start ? LEAD : IDLE) :
                   state == LEAD  ? SHIFT :
                   state == SHIFT ? (last_edge ? TAIL : SHIFT) : IDLE;
    end

    always_comb begin
        rval = bus.ctrl_addr == 8'h00 ? 32'(presc) :
               bus.ctrl_addr == 8'h04 ? 32'(cs) :
               bus.ctrl_addr == 8'h08 ? 32'(data) :
               bus.ctrl_addr == 8'h0C ? {29'b0, lsb, cpol, cpha} :
               bus.ctrl_addr == 8'h10 ? {26'b0, nbits} :
               bus.ctrl_addr == 8'h14 ? {31'b0, busy} : 32'b0;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            presc         <= '0;
            cs            <= '1;
            data          <= '0;
            nbits         <= 6'd8;
            cpol          <= 1'b0;
            cpha          <= 1'b0;
            act_presc     <= '0;
            act_nbits     <= 6'd8;
            act_cpol      <= 1'b0;
            act_cpha      <= 1'b0;
            hp            <= '0;
            edge_cnt      <= '0;
            spi_cs_n      <= '1;
            spi_sclk      <= 1'b0;
            spi_mosi      <= 1'b0;
            bus.ctrl_done <= 1'b0;
            bus.ctrl_rdat <= '0;
        end else begin
            bus.ctrl_done <= reg_acc || last_edge;
            bus.ctrl_rdat <= is_rd ? rval : '0;
            if (presc_wr) presc <= bus.ctrl_wdat[PRESC_W-1:0];
            if (cs_wr) cs <= bus.ctrl_wdat[CS_LENGTH-1:0];
            if (mode_wr) {cpol, cpha} <= bus.ctrl_wdat[1:0];
            if (nbits_wr) nbits <= (nb_w == 6'd0 || nb_w > 6'(DATA_WIDTH)) ? 6'(DATA_WIDTH) : nb_w;
            // pins follow CS/MODE only between transfers, so a running frame is never disturbed
            if (state == IDLE) begin
                spi_cs_n <= cs_wr ? bus.ctrl_wdat[CS_LENGTH-1:0] : cs;
                spi_sclk <= mode_wr ? bus.ctrl_wdat[1] : cpol;
            end
            if (start) begin
                data      <= bus.ctrl_wdat[DATA_WIDTH-1:0];
                act_presc <= presc;
                act_nbits <= nbits;
                act_cpol  <= cpol;
                act_cpha  <= cpha;
            end
            if (state == LEAD) begin
                data     <= data & mask;
                spi_mosi <= tx_bit;
                spi_sclk <= act_cpol;
                hp       <= '0;
                edge_cnt <= '0;
            end
            if (state == SHIFT) begin
                hp <= half_end ? '0 : hp + 1'b1;
                if (half_end) begin
                    spi_sclk <= ~spi_sclk;
                    edge_cnt <= edge_cnt + 7'd1;
                    if (edge_cnt[0] == act_cpha) data <= shifted;
                    else if (!last_edge) spi_mosi <= tx_bit;
                end
            end
        end
endmodule

// File: tb/tb_spi_master_wide.sv
// tb_spi_master_wide: table-driven register checks plus directed SPI transfer sequences.
module tb_spi_master_wide;
    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdat;
        logic [31:0] exp;
        string       name;
    } vec_t;

`ifdef SPI_MASTER_WIDE_LSB_EN
    localparam logic [31:0] MODE_RB = 32'h7;
`else
    localparam logic [31:0] MODE_RB = 32'h3;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  spi_cs_n;
    logic        spi_sclk, spi_mosi, spi_miso;
    logic        loop_en = 1'b1, miso_val = 1'b0, sclk_d = 1'b0;
    logic [31:0] cap = '0, r;
    int          errors = 0, checks = 0, rises = 0, since = 0, last_hp = 0, lat, n;
    vec_t        vecs [24];

    spi_master_wide_if bus();

    spi_master_wide dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    always #5 clk = ~clk;

    always @(posedge spi_sclk) begin
        rises = rises + 1;
        cap = {cap[30:0], spi_mosi};
    end

    // length in clk cycles of the most recent completed sclk half-period
    always @(posedge clk) begin
        if (spi_sclk !== sclk_d) begin
            last_hp <= since;
            since <= 1;
        end else since <= since + 1;
        sclk_d <= spi_sclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic rq, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int l);
        @(posedge clk); #1;
        bus.ctrl_wr = w; bus.ctrl_rd = rq; bus.ctrl_addr = a; bus.ctrl_wdat = d;
        l = 0;
        do begin @(posedge clk); #1; l++; end while (!bus.ctrl_done && l < 5000);
        rd = bus.ctrl_rdat;
        if (!bus.ctrl_done) begin
            checks++; errors++;
            $display("FAIL timeout addr=0x%0h: no ctrl_done after %0d cycles", a, l);
        end
        bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0;
    endtask

    task automatic wreg(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] x; int l;
        access(1'b1, 1'b0, a, d, x, l);
    endtask

    task automatic rreg(input logic [7:0] a, output logic [31:0] x);
        int l;
        access(1'b0, 1'b1, a, 32'h0, x, l);
    endtask

    task automatic start_xfer(input logic [31:0] d);
        @(posedge clk); #1;
        bus.ctrl_wr = 1'b1; bus.ctrl_addr = 8'h08; bus.ctrl_wdat = d;
        @(posedge clk); #1;
        bus.ctrl_wr = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 32'h0,     32'h0,   "presc_rst"};
        vecs[1]  = '{1'b0, 1'b1, 8'h04, 32'h0,     32'hFF,  "cs_rst"};
        vecs[2]  = '{1'b0, 1'b1, 8'h08, 32'h0,     32'h0,   "data_rst"};
        vecs[3]  = '{1'b0, 1'b1, 8'h0C, 32'h0,     32'h0,   "mode_rst"};
        vecs[4]  = '{1'b0, 1'b1, 8'h10, 32'h0,     32'd8,   "nbits_rst"};
        vecs[5]  = '{1'b0, 1'b1, 8'h14, 32'h0,     32'h0,   "stat_rst"};
        vecs[6]  = '{1'b0, 1'b1, 8'h18, 32'h0,     32'h0,   "unmapped_rd"};
        vecs[7]  = '{1'b1, 1'b0, 8'h18, 32'hFFFF,  32'h0,   "unmapped_wr"};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 32'h0,     32'h0,   "presc_after_unmapped"};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 32'h12345, 32'h0,   "presc_wr"};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 32'h0,     32'h2345, "presc_rd"};
        vecs[11] = '{1'b1, 1'b0, 8'h10, 32'h0,     32'h0,   "nbits_wr0"};
        vecs[12] = '{1'b0, 1'b1, 8'h10, 32'h0,     32'd32,  "nbits_clamp0"};
        vecs[13] = '{1'b1, 1'b0, 8'h10, 32'd5,     32'h0,   "nbits_wr5"};
        vecs[14] = '{1'b0, 1'b1, 8'h10, 32'h0,     32'd5,   "nbits_5"};
        vecs[15] = '{1'b1, 1'b0, 8'h10, 32'd33,    32'h0,   "nbits_wr33"};
        vecs[16] = '{1'b0, 1'b1, 8'h10, 32'h0,     32'd32,  "nbits_clamp33"};
        vecs[17] = '{1'b1, 1'b0, 8'h0C, 32'h7,     32'h0,   "mode_wr"};
        vecs[18] = '{1'b0, 1'b1, 8'h0C, 32'h0,     MODE_RB, "mode_rd"};
        vecs[19] = '{1'b1, 1'b1, 8'h00, 32'h7,     32'h0,   "wr_rd_same"};
        vecs[20] = '{1'b0, 1'b1, 8'h00, 32'h0,     32'h7,   "wr_wins"};
        vecs[21] = '{1'b1, 1'b0, 8'h04, 32'hFE,    32'h0,   "cs_wr"};
        vecs[22] = '{1'b0, 1'b1, 8'h04, 32'h0,     32'hFE,  "cs_rd"};
        vecs[23] = '{1'b0, 1'b1, 8'h14, 32'h0,     32'h0,   "stat_idle"};
        bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0; bus.ctrl_addr = '0; bus.ctrl_wdat = '0;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(spi_cs_n), 32'hFF);
        chk("rst_sclk", 32'(spi_sclk), 32'h0);
        chk("rst_mosi", 32'(spi_mosi), 32'h0);
        chk("rst_done", 32'(bus.ctrl_done), 32'h0);
        chk("rst_rdat", bus.ctrl_rdat, 32'h0);
        resetn = 1'b1;
        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdat, r, lat);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
            if (vecs[i].rd && !vecs[i].wr) chk(vecs[i].name, r, vecs[i].exp);
        end
        chk("cs_pin", 32'(spi_cs_n), 32'hFE);

        // mode 0, presc 0, 8 bits, loopback
        wreg(8'h0C, 32'h0);
        chk("sclk_idle0", 32'(spi_sclk), 32'h0);
        wreg(8'h00, 32'h0);
        wreg(8'h10, 32'd8);
        loop_en = 1'b1; rises = 0; cap = '0;
        access(1'b1, 1'b0, 8'h08, 32'hA5, r, lat);
        chk("t1_lat", 32'(lat), 32'd18);
        chk("t1_rises", 32'(rises), 32'd8);
        chk("t1_tx", cap & 32'hFF, 32'hA5);
        chk("t1_half", 32'(last_hp), 32'd1);
        chk("t1_mosi_hold", 32'(spi_mosi), 32'h1);
        chk("t1_sclk_tail", 32'(spi_sclk), 32'h0);
        rreg(8'h08, r);
        chk("t1_data", r, 32'hA5);

        // mode 3, presc 3, 16 bits, miso high
        wreg(8'h0C, 32'h3);
        chk("sclk_idle1", 32'(spi_sclk), 32'h1);
        wreg(8'h00, 32'h3);
        wreg(8'h10, 32'd16);
        loop_en = 1'b0; miso_val = 1'b1; rises = 0; cap = '0;
        access(1'b1, 1'b0, 8'h08, 32'h1234, r, lat);
        chk("t2_lat", 32'(lat), 32'd130);
        chk("t2_rises", 32'(rises), 32'd16);
        chk("t2_tx", cap & 32'hFFFF, 32'h1234);
        chk("t2_half", 32'(last_hp), 32'd4);
        chk("t2_sclk_tail", 32'(spi_sclk), 32'h1);
        rreg(8'h08, r);
        chk("t2_data", r, 32'hFFFF);

        // full-width transfer via NBITS=0
        wreg(8'h0C, 32'h0);
        wreg(8'h00, 32'h0);
        wreg(8'h10, 32'h0);
        rreg(8'h10, r);
        chk("t3_nbits", r, 32'd32);
        loop_en = 1'b1; rises = 0; cap = '0;
        access(1'b1, 1'b0, 8'h08, 32'hDEADBEEF, r, lat);
        chk("t3_lat", 32'(lat), 32'd66);
        chk("t3_tx", cap, 32'hDEADBEEF);
        rreg(8'h08, r);
        chk("t3_data", r, 32'hDEADBEEF);

        // status while busy, done spacing, then idle status
        wreg(8'h00, 32'h7);
        wreg(8'h10, 32'd8);
        start_xfer(32'h3C);
        rreg(8'h14, r);
        chk("t6_busy_a", r, 32'h1);
        rreg(8'h14, r);
        chk("t6_busy_b", r, 32'h1);
        wreg(8'h10, 32'd4);
        @(posedge clk); #1;
        bus.ctrl_rd = 1'b1; bus.ctrl_addr = 8'h14;
        n = 0;
        repeat (4) begin @(posedge clk); #1; if (bus.ctrl_done) n++; end
        bus.ctrl_rd = 1'b0;
        chk("t6_done_spacing", 32'(n), 32'd2);
        n = 0;
        while (!bus.ctrl_done && n < 500) begin @(posedge clk); #1; n++; end
        chk("t6_xfer_done", 32'(bus.ctrl_done), 32'h1);
        rreg(8'h14, r);
        chk("t6_idle", r, 32'h0);
        rreg(8'h08, r);
        chk("t6_data", r, 32'h3C);
        loop_en = 1'b1; cap = '0;
        access(1'b1, 1'b0, 8'h08, 32'h9, r, lat);
        chk("t6_nbits_next", 32'(lat), 32'd66);

`ifdef SPI_MASTER_WIDE_LSB_EN
        wreg(8'h0C, 32'h4);
        wreg(8'h00, 32'h0);
        wreg(8'h10, 32'd8);
        loop_en = 1'b1; cap = '0;
        access(1'b1, 1'b0, 8'h08, 32'h01, r, lat);
        chk("t5_lsb_tx", cap & 32'hFF, 32'h80);
        rreg(8'h08, r);
        chk("t5_lsb_data", r, 32'h01);
`endif

        // asynchronous reset in the middle of a transfer
        wreg(8'h0C, 32'h3);
        wreg(8'h00, 32'h3);
        wreg(8'h10, 32'd16);
        wreg(8'h04, 32'h7F);
        start_xfer(32'h5555);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_cs_mid", 32'(spi_cs_n), 32'h7F);
        #2 resetn = 1'b0;
        #1;
        chk("t4_cs_n", 32'(spi_cs_n), 32'hFF);
        chk("t4_sclk", 32'(spi_sclk), 32'h0);
        chk("t4_done", 32'(bus.ctrl_done), 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        rreg(8'h14, r);
        chk("t4_stat", r, 32'h0);
        rreg(8'h0C, r);
        chk("t4_mode", r, 32'h0);
        rreg(8'h04, r);
        chk("t4_cs_reg", r, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
